// File: rtl/wb_pkg.sv
// Shared widths, source identifiers and grant encoding for the register-file
// writeback path.
package wb_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int NUM_SRC    = 3;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LSU = 2'd1;
  localparam logic [1:0] SRC_MDU = 2'd2;

  // One-hot grant vector, indexed by the SRC_* constants.
  typedef logic [NUM_SRC-1:0] grant_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set at issue
// and cleared when the register file commits the write.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                  SYS_clk,
  input  logic                  SYS_reset,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  output logic [NUM_REGS-1:0]   pending
);

  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid) set_mask[set_rd] = 1'b1;
    if (clr_valid) clr_mask[clr_rd] = 1'b1;
  end

  // Set is OR'ed in after the clear, so a new producer issued in the commit
  // cycle of the old one keeps the bit. x0 never has a producer.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) pending <= '0;
    else            pending <= ((pending & ~clr_mask) | set_mask) & ~NUM_REGS'(1);
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Arbitrates ALU/LSU/MDU results onto the single register-file write port
// with ALU starvation protection, and tracks outstanding destinations.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = wb_pkg::XLEN
) (
  input  logic                  SYS_clk,
  input  logic                  SYS_reset,
  input  logic                  ALU_wb_valid,
  output logic                  ALU_wb_ready,
  input  logic [REG_ADDR_W-1:0] ALU_wb_rd,
  input  logic [XLEN-1:0]       ALU_wb_value,
  input  logic                  LSU_wb_valid,
  output logic                  LSU_wb_ready,
  input  logic [REG_ADDR_W-1:0] LSU_wb_rd,
  input  logic [XLEN-1:0]       LSU_wb_value,
  input  logic                  MDU_wb_valid,
  output logic                  MDU_wb_ready,
  input  logic [REG_ADDR_W-1:0] MDU_wb_rd,
  input  logic [XLEN-1:0]       MDU_wb_value,
  input  logic                  ISSUE_valid,
  input  logic [REG_ADDR_W-1:0] ISSUE_rd,
  output logic                  REG_write_enable,
  output logic [REG_ADDR_W-1:0] REG_write_address,
  output logic [XLEN-1:0]       REG_write_value,
  output logic [NUM_REGS-1:0]   WB_pending,
  output logic [31:0]           WB_count
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= CNT_W'(STARVE_LIMIT)) return CNT_W'(STARVE_LIMIT);
    return v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0]      starve_cnt;
  logic                  alu_starved;
  grant_t                gnt_p0;
  logic                  vld_p0;
  logic [REG_ADDR_W-1:0] rd_p0;
  logic [XLEN-1:0]       val_p0;

  // ---- stage p0: arbitration and source mux ----
  always_comb begin
    gnt_p0      = '0;
    alu_starved = ALU_wb_valid && (starve_cnt >= CNT_W'(STARVE_LIMIT));
    if (!SYS_reset)        gnt_p0          = '0;
    else if (alu_starved)  gnt_p0[SRC_ALU] = 1'b1;
    else if (LSU_wb_valid) gnt_p0[SRC_LSU] = 1'b1;
    else if (MDU_wb_valid) gnt_p0[SRC_MDU] = 1'b1;
    else if (ALU_wb_valid) gnt_p0[SRC_ALU] = 1'b1;
  end

  assign ALU_wb_ready = gnt_p0[SRC_ALU];
  assign LSU_wb_ready = gnt_p0[SRC_LSU];
  assign MDU_wb_ready = gnt_p0[SRC_MDU];

  always_comb begin
    vld_p0 = |gnt_p0;
    rd_p0  = ALU_wb_rd;
    val_p0 = ALU_wb_value;
    if (gnt_p0[SRC_LSU]) begin
      rd_p0  = LSU_wb_rd;
      val_p0 = LSU_wb_value;
    end else if (gnt_p0[SRC_MDU]) begin
      rd_p0  = MDU_wb_rd;
      val_p0 = MDU_wb_value;
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset)                          starve_cnt <= '0;
    else if (!ALU_wb_valid || ALU_wb_ready)  starve_cnt <= '0;
    else                                     starve_cnt <= sat_inc(starve_cnt);
  end

  // ---- stage p1: register-file write port ----
  // rd=0 grants consume the result but never raise the write strobe.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      REG_write_enable  <= 1'b0;
      REG_write_address <= '0;
      REG_write_value   <= '0;
    end else begin
      REG_write_enable <= vld_p0 && (rd_p0 != '0);
      if (vld_p0) begin
        REG_write_address <= rd_p0;
        REG_write_value   <= val_p0;
      end
    end
  end

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset)            WB_count <= '0;
    else if (REG_write_enable) WB_count <= WB_count + 32'd1;
  end

  wb_scoreboard u_scoreboard (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .set_valid (ISSUE_valid && (ISSUE_rd != '0)),
    .set_rd    (ISSUE_rd),
    .clr_valid (REG_write_enable),
    .clr_rd    (REG_write_address),
    .pending   (WB_pending)
  );

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected writes are queued at issue
// and a monitor pops and compares them whenever the write strobe is high.
module tb_writeback_arbiter;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        ALU_wb_valid, ALU_wb_ready;
  logic [4:0]  ALU_wb_rd;
  logic [31:0] ALU_wb_value;
  logic        LSU_wb_valid, LSU_wb_ready;
  logic [4:0]  LSU_wb_rd;
  logic [31:0] LSU_wb_value;
  logic        MDU_wb_valid, MDU_wb_ready;
  logic [4:0]  MDU_wb_rd;
  logic [31:0] MDU_wb_value;
  logic        ISSUE_valid;
  logic [4:0]  ISSUE_rd;
  logic        REG_write_enable;
  logic [4:0]  REG_write_address;
  logic [31:0] REG_write_value;
  logic [31:0] WB_pending;
  logic [31:0] WB_count;

  always #5 SYS_clk = ~SYS_clk;

  writeback_arbiter #(.STARVE_LIMIT(4), .XLEN(32)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .ALU_wb_valid(ALU_wb_valid), .ALU_wb_ready(ALU_wb_ready),
    .ALU_wb_rd(ALU_wb_rd), .ALU_wb_value(ALU_wb_value),
    .LSU_wb_valid(LSU_wb_valid), .LSU_wb_ready(LSU_wb_ready),
    .LSU_wb_rd(LSU_wb_rd), .LSU_wb_value(LSU_wb_value),
    .MDU_wb_valid(MDU_wb_valid), .MDU_wb_ready(MDU_wb_ready),
    .MDU_wb_rd(MDU_wb_rd), .MDU_wb_value(MDU_wb_value),
    .ISSUE_valid(ISSUE_valid), .ISSUE_rd(ISSUE_rd),
    .REG_write_enable(REG_write_enable), .REG_write_address(REG_write_address),
    .REG_write_value(REG_write_value), .WB_pending(WB_pending), .WB_count(WB_count)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  exp_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] val);
    wr_t e;
    e.rd  = rd;
    e.val = val;
    exp_q.push_back(e);
    exp_cnt++;
  endtask

  task automatic step();
    @(posedge SYS_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge SYS_clk);
  endtask

  // Monitor: every committed write must match the oldest queued expectation.
  always @(negedge SYS_clk) begin
    if (SYS_reset === 1'b1 && REG_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d value 0x%0h, none queued", REG_write_address, REG_write_value);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wb_addr", 64'(REG_write_address), 64'(e.rd));
        check("wb_value", 64'(REG_write_value), 64'(e.val));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    SYS_reset = 1'b0;
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd1; ALU_wb_value = 32'h1;
    LSU_wb_valid = 1'b0; LSU_wb_rd = 5'd0; LSU_wb_value = 32'h0;
    MDU_wb_valid = 1'b0; MDU_wb_rd = 5'd0; MDU_wb_value = 32'h0;
    ISSUE_valid  = 1'b0; ISSUE_rd  = 5'd0;

    // Reset state, including ready held low despite a valid source.
    step(); step();
    at_neg();
    check("rst_alu_ready", 64'(ALU_wb_ready), 64'd0);
    check("rst_enable", 64'(REG_write_enable), 64'd0);
    check("rst_address", 64'(REG_write_address), 64'd0);
    check("rst_value", 64'(REG_write_value), 64'd0);
    check("rst_pending", 64'(WB_pending), 64'd0);
    check("rst_count", 64'(WB_count), 64'd0);
    ALU_wb_valid = 1'b0;
    step();
    SYS_reset = 1'b1;

    // Single ALU write, rd=5.
    step();
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd5; ALU_wb_value = 32'h1234;
    expect_wr(5'd5, 32'h1234);
    at_neg();
    check("t1_alu_ready", 64'(ALU_wb_ready), 64'd1);
    step();
    ALU_wb_valid = 1'b0;
    at_neg();
    check("t1_enable", 64'(REG_write_enable), 64'd1);
    check("t1_count_n1", 64'(WB_count), 64'd0);
    step();
    at_neg();
    check("t1_count", 64'(WB_count), 64'd1);

    // All three sources at once: LSU, MDU, ALU on consecutive cycles.
    step();
    LSU_wb_valid = 1'b1; LSU_wb_rd = 5'd1; LSU_wb_value = 32'hA1;
    MDU_wb_valid = 1'b1; MDU_wb_rd = 5'd2; MDU_wb_value = 32'hB2;
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd3; ALU_wb_value = 32'hC3;
    expect_wr(5'd1, 32'hA1);
    expect_wr(5'd2, 32'hB2);
    expect_wr(5'd3, 32'hC3);
    at_neg();
    check("t2_rdy_c0", 64'({LSU_wb_ready, MDU_wb_ready, ALU_wb_ready}), 64'b100);
    step();
    LSU_wb_valid = 1'b0;
    at_neg();
    check("t2_rdy_c1", 64'({LSU_wb_ready, MDU_wb_ready, ALU_wb_ready}), 64'b010);
    check("t2_en_c1", 64'(REG_write_enable), 64'd1);
    step();
    MDU_wb_valid = 1'b0;
    at_neg();
    check("t2_rdy_c2", 64'({LSU_wb_ready, MDU_wb_ready, ALU_wb_ready}), 64'b001);
    check("t2_en_c2", 64'(REG_write_enable), 64'd1);
    step();
    ALU_wb_valid = 1'b0;
    at_neg();
    check("t2_en_c3", 64'(REG_write_enable), 64'd1);
    step();

    // Starvation: ALU must win on its 5th waiting cycle, then LSU resumes.
    LSU_wb_valid = 1'b1; LSU_wb_rd = 5'd8; LSU_wb_value = 32'h800;
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd9; ALU_wb_value = 32'h99;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) expect_wr(5'd9, 32'h99);
      else        expect_wr(5'd8, LSU_wb_value);
      at_neg();
      check($sformatf("t3_alu_rdy_%0d", i), 64'(ALU_wb_ready), 64'(i == 4));
      check($sformatf("t3_lsu_rdy_%0d", i), 64'(LSU_wb_ready), 64'(i != 4));
      step();
      if (i == 4) ALU_wb_valid = 1'b0;
      else        LSU_wb_value = LSU_wb_value + 32'd1;
    end
    LSU_wb_valid = 1'b0;
    step(); step();
    at_neg();
    check("t3_count", 64'(WB_count), 64'(exp_cnt));

    // Pending bit lifetime: set at issue, cleared at the edge ending the write.
    step();
    ISSUE_valid = 1'b1; ISSUE_rd = 5'd7;
    step();
    ISSUE_valid = 1'b0;
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd7; ALU_wb_value = 32'h77;
    expect_wr(5'd7, 32'h77);
    at_neg();
    check("t4_pend_n", 64'(WB_pending), 64'h80);
    step();
    ALU_wb_valid = 1'b0;
    at_neg();
    check("t4_pend_n1", 64'(WB_pending), 64'h80);
    step();
    at_neg();
    check("t4_pend_n2", 64'(WB_pending), 64'h0);

    // Re-issue to rd=7 in the commit cycle of rd=7: set must win.
    step();
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd7; ALU_wb_value = 32'h55;
    expect_wr(5'd7, 32'h55);
    step();
    ALU_wb_valid = 1'b0;
    ISSUE_valid = 1'b1; ISSUE_rd = 5'd7;
    at_neg();
    check("t5_en", 64'(REG_write_enable), 64'd1);
    step();
    ISSUE_valid = 1'b0;
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd7; ALU_wb_value = 32'h56;
    expect_wr(5'd7, 32'h56);
    at_neg();
    check("t5_pend_kept", 64'(WB_pending), 64'h80);
    step();
    ALU_wb_valid = 1'b0;
    step();
    at_neg();
    check("t5_pend_cleared", 64'(WB_pending), 64'h0);

    // rd=0: accepted, no write, no count, no pending bit 0.
    step();
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd0; ALU_wb_value = 32'hDEAD;
    ISSUE_valid = 1'b1; ISSUE_rd = 5'd0;
    at_neg();
    check("t6_ready", 64'(ALU_wb_ready), 64'd1);
    step();
    ALU_wb_valid = 1'b0; ISSUE_valid = 1'b0;
    at_neg();
    check("t6_enable", 64'(REG_write_enable), 64'd0);
    check("t6_pending", 64'(WB_pending), 64'h0);
    step();
    at_neg();
    check("t6_count", 64'(WB_count), 64'(exp_cnt));

    // Asynchronous reset while a write sits in the output stage.
    step();
    ISSUE_valid = 1'b1; ISSUE_rd = 5'd3;
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd4; ALU_wb_value = 32'h44;
    step();
    ISSUE_valid = 1'b0; ALU_wb_valid = 1'b0;
    #1;
    check("t7_pre_en", 64'(REG_write_enable), 64'd1);
    check("t7_pre_pend", 64'(WB_pending), 64'h8);
    SYS_reset = 1'b0;
    #1;
    check("t7_en", 64'(REG_write_enable), 64'd0);
    check("t7_pend", 64'(WB_pending), 64'h0);
    check("t7_count", 64'(WB_count), 64'd0);
    step();
    SYS_reset = 1'b1;
    exp_cnt = 0;

    // Recovery after reset.
    step();
    ALU_wb_valid = 1'b1; ALU_wb_rd = 5'd6; ALU_wb_value = 32'h66;
    expect_wr(5'd6, 32'h66);
    step();
    ALU_wb_valid = 1'b0;
    step(); step();
    at_neg();
    check("t8_count", 64'(WB_count), 64'(exp_cnt));
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writer-side front end of the integer register file: collects completed results from the ALU, the load/store unit (LSU) and the multiply/divide unit (MDU), arbitrates them onto the single register-file write port, and drives REG_write_enable/REG_write_address/REG_write_value one registered cycle later. Also keeps a 32-bit pending-write scoreboard that decode and hazard logic use to stall on destinations whose results have not yet been written.

## Interface
- STARVE_LIMIT, default 4: consecutive cycles the ALU may be valid and not granted before it gets top priority.
- XLEN, default 32: data width.
- SYS_clk  in  1  rising-edge clock.
- SYS_reset  in  1  asynchronous, active-low reset. One clock; reset asserts asynchronously and is active-low.
- ALU_wb_valid / ALU_wb_ready  in/out  1  ALU result handshake.
- ALU_wb_rd  in  5  ALU destination register.
- ALU_wb_value  in  XLEN  ALU result.
- LSU_wb_valid / LSU_wb_ready, LSU_wb_rd, LSU_wb_value: same as the ALU ports, for the LSU.
- MDU_wb_valid / MDU_wb_ready, MDU_wb_rd, MDU_wb_value: same as the ALU ports, for the MDU.
- ISSUE_valid  in  1  decode issues an instruction that writes a register.
- ISSUE_rd  in  5  destination of the issued instruction.
- REG_write_enable  out  1  register-file write strobe (registered).
- REG_write_address  out  5  register-file write index (registered).
- REG_write_value  out  XLEN  register-file write data (registered).
- WB_pending  out  32  scoreboard, one bit per register; bit 0 is constant 0.
- WB_count  out  32  count of committed writes with rd != 0.

## Operation
- Handshake: a transfer happens when valid && ready. valid must stay high, with rd and value stable, until accepted. ready is combinational from the valids and the arbiter state, and is high for at most one source per cycle.
- Default priority: LSU > MDU > ALU.
- Starvation counter: counts cycles with ALU_wb_valid=1 and ALU_wb_ready=0.
  - When it reaches STARVE_LIMIT, the ALU has top priority and is granted next.
  - The counter clears on an ALU grant or when ALU_wb_valid=0.
  - It saturates; it does not wrap.
- Output stage (one register):
  - On a grant, the next edge loads REG_write_address=rd, REG_write_value=value, REG_write_enable=(rd!=0).
  - With no grant, REG_write_enable=0 next cycle; address and value hold.
- rd=0 results are accepted and dropped: no write, no scoreboard change, no count.
- Scoreboard set: on ISSUE_valid with ISSUE_rd!=0, bit ISSUE_rd is set at the next edge.
- Scoreboard clear: the bit for REG_write_address is cleared at the edge that ends a cycle with REG_write_enable=1. This is the same edge at which the register file commits the value.
- Same-register set and clear in one cycle: set wins, because the new producer remains outstanding.
- Decode must not issue to a register whose WB_pending bit is 1 (WAW stall in decode). The arbiter does not check this.
- WB_count increments by 1 on each edge with REG_write_enable=1 and wraps modulo 2^32.

## Timing
- Reset values: REG_write_enable=0, REG_write_address=0, REG_write_value=0, WB_pending=0, WB_count=0, starvation counter=0. All *_ready outputs are 0 while SYS_reset=0.
- Grant in cycle N. REG_write_* valid in cycle N+1. Register-file contents readable from cycle N+2.
- Pending bit is cleared in the WB_pending value seen in N+2.
- Throughput: one write per cycle sustained. The output stage never back-pressures.
- Reset asserted mid-operation: the in-flight output write is discarded (enable forced to 0) and all pending bits clear. Sources must re-present their results after reset.

## Structure
- Shared package wb_pkg:
  - XLEN and REG_ADDR_W=5.
  - Source-ID constants SRC_ALU=2'd0, SRC_LSU=2'd1, SRC_MDU=2'd2.
  - Grant one-hot typedef.
- Sub-module wb_scoreboard:
  - Contains the 32-bit pending register with its set/clear and set-wins rule.
  - Instantiated once.
- Arbiter, starvation counter, output register and WB_count stay in the top level.

## Test plan
- Reset release, then ALU valid with rd=5, value=0x1234 in cycle N -> ALU_wb_ready=1 in N; REG_write_enable=1, address=5, value=0x1234 in N+1; WB_count=1.
- LSU, MDU and ALU all valid in the same cycle (rd=1, 2, 3) -> grants in order LSU, MDU, ALU over three consecutive cycles; three writes back-to-back.
- LSU valid continuously, ALU valid continuously, STARVE_LIMIT=4 -> ALU granted on its 5th valid cycle, then LSU resumes.
- ISSUE rd=7, then ALU writes rd=7 -> WB_pending[7]=1 until the edge ending the write cycle; 0 afterwards.
- ISSUE rd=7 in the same cycle as REG_write_enable=1 with address=7 -> WB_pending[7] stays 1.
- ALU result with rd=0 -> accepted, REG_write_enable=0, WB_count unchanged.
- SYS_reset pulsed low while a write is in the output stage -> REG_write_enable=0 immediately, WB_pending=0, WB_count=0.
